// File: rtl/rv32_pkg.sv
// Shared constants and helpers for the RV32 writeback path.
package rv32_pkg;

    localparam int NREQ = 4;
    localparam int XLEN = 32;

    // Requester index doubles as the writeback source code.
    localparam logic [1:0] SRC_ALU    = 2'd0;
    localparam logic [1:0] SRC_BSHIFT = 2'd1;
    localparam logic [1:0] SRC_PC     = 2'd2;
    localparam logic [1:0] SRC_DATA   = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Pointer value that makes the next search begin at requester 0.
    localparam logic [1:0] LAST_GRANT_RST = 2'd3;

    // Index of the set bit of a one-hot (or zero) 4-bit vector.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rv32_rr_arbiter4.sv
// Four-way round-robin arbiter; the search starts just after the last winner.
module rv32_rr_arbiter4
    import rv32_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_advance,
    input  logic            i_clear,
    output logic [NREQ-1:0] o_grant
);

    logic [1:0] r_last_grant;
    logic [1:0] w_idx;
    logic       w_found;

    // Walk the requesters from last_grant+1, wrapping, and grant the first valid one.
    always_comb begin
        o_grant = '0;
        w_idx   = 2'd0;
        w_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = r_last_grant + 2'(k);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    // Pointer update: clear restores the reset position, a completed grant moves it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= LAST_GRANT_RST;
        end else if (i_clear) begin
            r_last_grant <= LAST_GRANT_RST;
        end else if (i_advance) begin
            r_last_grant <= onehot_to_idx(o_grant);
        end
    end

endmodule

// File: rtl/rv32_writeback_arbiter.sv
// Register-bank write-port arbiter with a pending-destination scoreboard for RAW stalls.
module rv32_writeback_arbiter
    import rv32_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [5*NREQ-1:0] i_req_rd,
    input  logic [XLEN*NREQ-1:0] i_req_data,
    output logic [NREQ-1:0]   o_req_ready,
    output logic              o_wr_en,
    output logic [4:0]        o_wr_addr,
    output logic [XLEN-1:0]   o_wr_data,
    output logic [1:0]        o_wr_src,
    input  logic              i_iss_valid,
    input  logic [4:0]        i_iss_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    output logic              o_hazard,
    input  logic              i_flush,
    output logic              o_busy
);

    logic [NREQ-1:0] w_grant;
    logic            w_xfer;
    logic [1:0]      w_win_idx;
    logic [4:0]      w_win_rd;
    logic [XLEN-1:0] w_win_data;
    logic            w_commit;
    logic [31:0]     r_pending;
    logic [31:0]     w_pending_nxt;

    rv32_rr_arbiter4 u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (i_req_valid),
        .i_advance (w_xfer),
        .i_clear   (i_flush),
        .o_grant   (w_grant)
    );

    assign o_req_ready = w_grant;
    assign w_xfer      = |(w_grant & i_req_valid);
    assign w_win_idx   = onehot_to_idx(w_grant);

    // Select the winning requester's destination and data.
    always_comb begin
        w_win_rd   = i_req_rd[4:0];
        w_win_data = i_req_data[XLEN-1:0];
        case (w_win_idx)
            SRC_ALU: begin
                w_win_rd   = i_req_rd[4:0];
                w_win_data = i_req_data[XLEN-1:0];
            end
            SRC_BSHIFT: begin
                w_win_rd   = i_req_rd[9:5];
                w_win_data = i_req_data[2*XLEN-1:XLEN];
            end
            SRC_PC: begin
                w_win_rd   = i_req_rd[14:10];
                w_win_data = i_req_data[3*XLEN-1:2*XLEN];
            end
            default: begin
                w_win_rd   = i_req_rd[19:15];
                w_win_data = i_req_data[4*XLEN-1:3*XLEN];
            end
        endcase
    end

    // Writes to x0 still complete the grant but never reach the bank.
    assign w_commit = w_xfer && (w_win_rd != REG_ZERO);

    // Register the winning write; without a grant only the enable drops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wr_en   <= 1'b0;
            o_wr_addr <= REG_ZERO;
            o_wr_data <= '0;
            o_wr_src  <= SRC_ALU;
        end else begin
            o_wr_en <= w_commit;
            if (w_xfer) begin
                o_wr_addr <= w_win_rd;
                o_wr_data <= w_win_data;
                o_wr_src  <= w_win_idx;
            end
        end
    end

    // Scoreboard next state: commit clears, a same-cycle issue re-sets, flush wipes all.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_commit) w_pending_nxt[w_win_rd] = 1'b0;
        if (i_iss_valid && (i_iss_rd != REG_ZERO)) w_pending_nxt[i_iss_rd] = 1'b1;
        if (i_flush) w_pending_nxt = '0;
        w_pending_nxt[0] = 1'b0;
    end

    // Scoreboard and busy register together so busy tracks the stored bits exactly.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= '0;
            o_busy    <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            o_busy    <= |w_pending_nxt;
        end
    end

    // No bypass: a register committing this cycle still stalls until the edge.
    assign o_hazard = ((i_rs1 != REG_ZERO) && r_pending[i_rs1]) ||
                      ((i_rs2 != REG_ZERO) && r_pending[i_rs2]);

endmodule

// File: tb/tb_rv32_writeback_arbiter.sv
// Directed self-checking bench for the writeback arbiter.
module tb_rv32_writeback_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [19:0]  req_rd;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic [1:0]   wr_src;
    logic         iss_valid;
    logic [4:0]   iss_rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic         hazard;
    logic         flush;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32_writeback_arbiter dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_rd    (req_rd),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_wr_src    (wr_src),
        .i_iss_valid (iss_valid),
        .i_iss_rd    (iss_rd),
        .i_rs1       (rs1),
        .i_rs2       (rs2),
        .o_hazard    (hazard),
        .i_flush     (flush),
        .o_busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] data);
        req_valid[i]          = 1'b1;
        req_rd[5*i +: 5]      = rd;
        req_data[32*i +: 32]  = data;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        rs1       = '0;
        rs2       = '0;
        flush     = 1'b0;

        // Reset held three cycles, then idle
        repeat (3) tick();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_wr_src", 32'(wr_src), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_hazard", 32'(hazard), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_wr_en", 32'(wr_en), 32'd0);

        // Single write: issue rd=5, ALU returns it
        iss_valid = 1'b1;
        iss_rd    = 5'd5;
        tick();
        iss_valid = 1'b0;
        #1;
        chk("iss5_busy", 32'(busy), 32'd1);
        set_req(0, 5'd5, 32'hDEADBEEF);
        rs1 = 5'd5;
        #1;
        chk("single_ready", 32'(req_ready), 32'b0001);
        chk("single_hazard_pre", 32'(hazard), 32'd1);
        tick();
        req_valid = '0;
        #1;
        chk("single_wr_en", 32'(wr_en), 32'd1);
        chk("single_wr_addr", 32'(wr_addr), 32'd5);
        chk("single_wr_data", wr_data, 32'hDEADBEEF);
        chk("single_wr_src", 32'(wr_src), 32'd0);
        chk("single_busy", 32'(busy), 32'd0);
        chk("single_hazard_post", 32'(hazard), 32'd0);
        rs1 = 5'd0;

        // Flush to put the pointer back at requester 0
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Round robin: all four valid, rd = 1..4
        for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'h100 + 32'(i));
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << k));
            tick();
            req_valid[k] = 1'b0;
            #1;
            chk("rr_wr_en", 32'(wr_en), 32'd1);
            chk("rr_wr_addr", 32'(wr_addr), 32'(k + 1));
            chk("rr_wr_data", wr_data, 32'h100 + 32'(k));
            chk("rr_wr_src", 32'(wr_src), 32'(k));
        end
        // No grant: enable drops, address holds
        tick();
        chk("hold_wr_en", 32'(wr_en), 32'd0);
        chk("hold_wr_addr", 32'(wr_addr), 32'd4);
        // Re-present 2 and 0; 0 goes first
        set_req(2, 5'd3, 32'h202);
        set_req(0, 5'd1, 32'h200);
        #1;
        chk("rr2_ready_a", 32'(req_ready), 32'b0001);
        tick();
        req_valid[0] = 1'b0;
        #1;
        chk("rr2_src_a", 32'(wr_src), 32'd0);
        chk("rr2_ready_b", 32'(req_ready), 32'b0100);
        tick();
        req_valid[2] = 1'b0;
        #1;
        chk("rr2_src_b", 32'(wr_src), 32'd2);
        chk("rr2_data_b", wr_data, 32'h202);

        // x0 drop with rd=12 pending
        iss_valid = 1'b1;
        iss_rd    = 5'd12;
        tick();
        iss_valid = 1'b0;
        set_req(1, 5'd0, 32'h1234);
        #1;
        chk("x0_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        rs1 = 5'd12;
        #1;
        chk("x0_wr_en", 32'(wr_en), 32'd0);
        chk("x0_wr_src", 32'(wr_src), 32'd1);
        chk("x0_wr_data", wr_data, 32'h1234);
        chk("x0_busy", 32'(busy), 32'd1);
        chk("x0_hazard12", 32'(hazard), 32'd1);

        // Hazard on rd=7 through a load-data commit
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        tick();
        iss_valid = 1'b0;
        rs1 = 5'd7;
        #1;
        chk("haz_rs1_7", 32'(hazard), 32'd1);
        rs1 = 5'd0;
        #1;
        chk("haz_rs1_0", 32'(hazard), 32'd0);
        rs1 = 5'd7;
        set_req(3, 5'd7, 32'hABCD0007);
        #1;
        chk("haz_ld_ready", 32'(req_ready), 32'b1000);
        chk("haz_commit_cycle", 32'(hazard), 32'd1);
        tick();
        req_valid = '0;
        #1;
        chk("haz_after", 32'(hazard), 32'd0);
        chk("haz_wr_src", 32'(wr_src), 32'd3);
        chk("haz_wr_addr", 32'(wr_addr), 32'd7);
        rs1 = 5'd0;

        // Same-rd collision: commit rd=9 while issuing rd=9
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        tick();
        set_req(0, 5'd9, 32'h99);
        #1;
        chk("col_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        iss_valid = 1'b0;
        rs2 = 5'd9;
        #1;
        chk("col_wr_en", 32'(wr_en), 32'd1);
        chk("col_wr_addr", 32'(wr_addr), 32'd9);
        chk("col_hazard9", 32'(hazard), 32'd1);

        // Flush with a grant and an issue in the same cycle
        flush     = 1'b1;
        iss_valid = 1'b1;
        iss_rd    = 5'd11;
        set_req(0, 5'd10, 32'hCAFE0000);
        #1;
        chk("fl_ready", 32'(req_ready), 32'b0001);
        tick();
        flush     = 1'b0;
        iss_valid = 1'b0;
        req_valid = '0;
        rs1 = 5'd11;
        #1;
        chk("fl_wr_en", 32'(wr_en), 32'd1);
        chk("fl_wr_addr", 32'(wr_addr), 32'd10);
        chk("fl_wr_data", wr_data, 32'hCAFE0000);
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_hazard", 32'(hazard), 32'd0);
        // Pointer restored: 0 beats 1
        set_req(0, 5'd2, 32'h1);
        set_req(1, 5'd3, 32'h2);
        #1;
        chk("fl_ptr_ready", 32'(req_ready), 32'b0001);
        req_valid = '0;
        rs1 = 5'd0;
        rs2 = 5'd0;

        // Asynchronous reset mid-operation
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        set_req(2, 5'd6, 32'h66);
        tick();
        iss_valid = 1'b0;
        req_valid = '0;
        #1;
        chk("mid_busy_pre", 32'(busy), 32'd1);
        chk("mid_wr_en_pre", 32'(wr_en), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_wr_en", 32'(wr_en), 32'd0);
        chk("mid_wr_addr", 32'(wr_addr), 32'd0);
        chk("mid_wr_src", 32'(wr_src), 32'd0);
        tick();
        rst = 1'b0;
        set_req(1, 5'd4, 32'h44);
        set_req(3, 5'd8, 32'h88);
        #1;
        chk("mid_ptr_ready", 32'(req_ready), 32'b0010);
        req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_writeback_arbiter.md
Name: rv32_writeback_arbiter

Overview:
- Shares the single write port of the RV32 register bank between four result producers: ALU, barrel shifter, PC/link and load data.
- Arbitrates one write per cycle using round-robin, registers the winning write, and drops writes to x0.
- Keeps a 32-bit pending-destination scoreboard, set at issue and cleared at commit. Decode uses it to stall on RAW hazards for rs1/rs2.

Parameters:
- NREQ, 4, number of writeback requesters. Fixed at 4; the index equals the source_sel code (0 ALU, 1 shifter, 2 PC, 3 load data).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  4  requester i holds a result.
- req_rd  in  20  destination of requester i, bits [5i+4:5i].
- req_data  in  128  result of requester i, bits [32i+31:32i].
- req_ready  out  4  one-hot grant (combinational); a transfer occurs when req_valid[i] & req_ready[i].
- wr_en  out  1  registered register-bank write enable.
- wr_addr  out  5  registered write destination.
- wr_data  out  32  registered write data.
- wr_src  out  2  registered source code of the winning requester.
- iss_valid  in  1  decode issues an instruction that writes rd.
- iss_rd  in  5  destination of the issued instruction.
- rs1, rs2  in  5 each  decode source selects.
- hazard  out  1  combinational; high when rs1 or rs2 is pending and non-zero.
- flush  in  1  synchronous clear of the scoreboard and the arbiter pointer.
- busy  out  1  registered; high when any scoreboard bit is set.

Behaviour:
- Reset values (rst asserted asynchronously): wr_en=0, wr_addr=0, wr_data=0, wr_src=0, pending=0, busy=0, last_grant=3. The first search after reset therefore starts at requester 0.
- Arbitration (combinational):
  - Search req_valid starting at (last_grant+1) mod 4 and wrapping around.
  - The first valid requester gets req_ready; at most one bit of req_ready is set.
  - No valid requester gives req_ready=0.
- Grant at edge N (transfer with winner i):
  - wr_en=1 if req_rd[i]!=0, otherwise 0 (the write is dropped, but the grant still completes).
  - wr_addr=req_rd[i], wr_data=req_data[i], wr_src=i.
  - last_grant=i.
- No grant at edge N: wr_en=0 and wr_addr/wr_data/wr_src hold their values. last_grant holds.
- Latency: the register bank sees the write one cycle after the grant cycle.
- A requester must hold valid, rd and data stable until granted. The arbiter never grants without valid.
- Scoreboard update at each edge, where commit = the transfer with rd!=0:
  - pending[commit_rd] is cleared.
  - pending[iss_rd] is set if iss_valid and iss_rd!=0.
  - If both name the same rd in one cycle, set wins; the later producer is still outstanding.
  - pending[0] is always 0.
- hazard = (rs1!=0 & pending[rs1]) | (rs2!=0 & pending[rs2]). There is no bypass: a register that commits this cycle still reads as pending until the edge.
- busy = |pending, registered from the next-state value so it is coincident with the scoreboard.
- flush at an edge:
  - pending=0 and last_grant=3.
  - An iss_valid in the same cycle is ignored.
  - A grant in the same cycle still commits to wr_*.
- rst mid-operation: everything returns to reset values immediately. Requesters must re-present their results.

Decomposition:
- Shared package rv32_pkg holds:
  - constants SRC_ALU=0, SRC_BSHIFT=1, SRC_PC=2, SRC_DATA=3;
  - REG_ZERO=5'd0;
  - XLEN.
- One natural sub-module, rv32_rr_arbiter4: 4-way round-robin grant with last_grant state. Its inputs are req, advance, clear and clk/rst; its output is the one-hot grant.
- The scoreboard stays inline.

Test Plan:
- Reset then idle, rst held 3 cycles: all outputs are 0 and busy=0. After release with no requests, wr_en stays 0.
- Single write: iss_valid with iss_rd=5, then ALU presents rd=5, data=0xDEADBEEF. Required response:
  - req_ready=4'b0001;
  - next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, wr_src=0;
  - pending[5] clears and busy drops.
- Round-robin: all four valid with rd=1..4, held until granted. Grants go 0,1,2,3 on consecutive cycles. Then re-assert 2 and 0 only; requester 0 is granted before 2 (last_grant=3).
- x0 drop: the shifter presents rd=0, data=0x1234. req_ready[1]=1, and the next cycle wr_en=0 and wr_src=1. The scoreboard is unchanged.
- Hazard: issue rd=7, then rs1=7 gives hazard=1 while rs1=0 gives hazard=0. In the cycle of load-data commit to rd=7, hazard is still 1; it becomes 0 the following cycle.
- Same-rd collision and flush:
  - Commit to rd=9 and iss_rd=9 in the same cycle: pending[9] stays 1.
  - A later flush clears pending and busy, while a grant in the flush cycle still produces wr_en=1.
